reg_bank8_wb: RTL and testbench



---
 rtl/reg_bank8_wb.sv | 61 ++++++
 tb/tb_reg_bank8_wb.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/reg_bank8_wb.sv
// reg_bank8_wb: eight-entry register bank with a staged write-back port and forwarding read ports
module reg_bank8_wb #(
  parameter int WIDTH     = 64,
  parameter bit ZERO_LAST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             freeze,
  input  logic [2:0]       rd_addr_a,
  input  logic [2:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic [7:0]       commit_onehot,
  output logic             stage_busy
);
  localparam logic [7:0] MASK = ZERO_LAST ? 8'h7f : 8'hff;
  logic             r_stage_valid;
  logic [2:0]       r_stage_addr;
  logic [WIDTH-1:0] r_stage_data;
  logic [WIDTH-1:0] r_mem [8];
  logic             w_accept;
  logic [7:0]       w_commit;
  assign wr_ready      = ~freeze;
  assign w_accept      = wr_valid & ~freeze;
  assign w_commit      = r_stage_valid ? ((8'd1 << r_stage_addr) & MASK) : 8'd0;
  assign commit_onehot = w_commit;
  assign stage_busy    = r_stage_valid;
  // stage register: captures an accepted write, empties when nothing is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stage_valid <= 1'b0;
      r_stage_addr  <= 3'd0;
      r_stage_data  <= '0;
    end else begin
      r_stage_valid <= w_accept;
      if (w_accept) begin
        r_stage_addr <= wr_addr;
        r_stage_data <= wr_data;
      end
    end
  end
  // array commit through the one-hot enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) if (w_commit[i]) r_mem[i] <= r_stage_data;
    end
  end
  // read ports: zero entry first, then the staged write, then the array
  always_comb begin
    rd_data_a = (ZERO_LAST && rd_addr_a == 3'd7) ? '0 :
                (r_stage_valid && r_stage_addr == rd_addr_a) ? r_stage_data : r_mem[rd_addr_a];
    rd_data_b = (ZERO_LAST && rd_addr_b == 3'd7) ? '0 :
                (r_stage_valid && r_stage_addr == rd_addr_b) ? r_stage_data : r_mem[rd_addr_b];
  end
endmodule

// File: tb/tb_reg_bank8_wb.sv
// tb_reg_bank8_wb: directed scoreboard bench for both zero-entry variants of reg_bank8_wb
module tb_reg_bank8_wb;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_valid;
  logic [2:0]  wr_addr;
  logic [63:0] wr_data;
  logic        freeze;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic        rdy1, rdy0, sb1, sb0;
  logic [63:0] ra1, rb1, ra0, rb0;
  logic [7:0]  co1, co0;
  logic [63:0] m1 [8];
  logic [63:0] m0 [8];
  logic        ms_v;
  logic [2:0]  ms_a;
  logic [63:0] ms_d;
  logic [63:0] exp_q [$];
  string       step;
  int          vectors = 0;
  int          miscompares = 0;
  always #5 clk = ~clk;
  reg_bank8_wb #(.WIDTH(64), .ZERO_LAST(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(rdy1), .wr_addr(wr_addr),
    .wr_data(wr_data), .freeze(freeze), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(ra1), .rd_data_b(rb1), .commit_onehot(co1), .stage_busy(sb1));
  reg_bank8_wb #(.WIDTH(64), .ZERO_LAST(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(rdy0), .wr_addr(wr_addr),
    .wr_data(wr_data), .freeze(freeze), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(ra0), .rd_data_b(rb0), .commit_onehot(co0), .stage_busy(sb0));
  function automatic logic [63:0] e_rd(input bit z, input logic [2:0] a);
    if (z && a == 3'd7) return 64'd0;
    if (ms_v && ms_a == a) return ms_d;
    return z ? m1[a] : m0[a];
  endfunction
  function automatic logic [63:0] e_co(input bit z);
    logic [7:0] oh;
    oh = ms_v ? (8'd1 << ms_a) : 8'd0;
    if (z) oh[7] = 1'b0;
    return {56'd0, oh};
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m1[i] = 64'd0;
      m0[i] = 64'd0;
    end
    ms_v = 1'b0;
    ms_a = 3'd0;
    ms_d = 64'd0;
  endtask
  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      if (ms_v) begin
        if (ms_a != 3'd7) m1[ms_a] = ms_d;
        m0[ms_a] = ms_d;
      end
      ms_v = wr_valid && !freeze;
      if (ms_v) begin
        ms_a = wr_addr;
        ms_d = wr_data;
      end
    end
    #1;
  endtask
  task automatic cmp(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    e = exp_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, e);
    end
  endtask
  task automatic check(input string s);
    step = s;
    #1;
    exp_q.push_back(e_rd(1'b1, rd_addr_a));
    exp_q.push_back(e_rd(1'b1, rd_addr_b));
    exp_q.push_back(e_co(1'b1));
    exp_q.push_back({63'd0, ms_v});
    exp_q.push_back({63'd0, ~freeze});
    exp_q.push_back(e_rd(1'b0, rd_addr_a));
    exp_q.push_back(e_rd(1'b0, rd_addr_b));
    exp_q.push_back(e_co(1'b0));
    exp_q.push_back({63'd0, ms_v});
    exp_q.push_back({63'd0, ~freeze});
    cmp("rd_a_z1", ra1);
    cmp("rd_b_z1", rb1);
    cmp("commit_z1", {56'd0, co1});
    cmp("busy_z1", {63'd0, sb1});
    cmp("ready_z1", {63'd0, rdy1});
    cmp("rd_a_z0", ra0);
    cmp("rd_b_z0", rb0);
    cmp("commit_z0", {56'd0, co0});
    cmp("busy_z0", {63'd0, sb0});
    cmp("ready_z0", {63'd0, rdy0});
  endtask
  task automatic wr(input logic [2:0] a, input logic [63:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
  endtask
  initial begin
    reset_n = 1'b0; wr_valid = 1'b0; wr_addr = 3'd0; wr_data = 64'd0; freeze = 1'b0;
    rd_addr_a = 3'd0; rd_addr_b = 3'd7;
    model_reset();
    check("reset_init");
    tick();
    reset_n = 1'b1;
    tick();
    check("after_release");
    wr(3'd2, 64'd5); rd_addr_a = 3'd2;
    tick();
    wr_valid = 1'b0;
    check("staged_2");
    reset_n = 1'b0;
    model_reset();
    check("reset_mid");
    tick();
    reset_n = 1'b1;
    tick();
    check("reset_dropped");
    wr(3'd3, 64'hAB); rd_addr_a = 3'd3; rd_addr_b = 3'd2;
    tick();
    wr_valid = 1'b0;
    check("fwd_3");
    tick();
    check("array_3");
    wr(3'd1, 64'd1); rd_addr_a = 3'd1; rd_addr_b = 3'd3;
    tick();
    wr(3'd1, 64'd2);
    check("b2b_first");
    tick();
    wr_valid = 1'b0;
    check("b2b_second");
    tick();
    check("b2b_array");
    tick();
    check("b2b_hold");
    wr(3'd7, 64'hFF); rd_addr_a = 3'd7; rd_addr_b = 3'd7;
    check("zero_pre");
    tick();
    wr_valid = 1'b0;
    check("zero_staged");
    tick();
    check("zero_array");
    wr(3'd4, 64'd9); rd_addr_a = 3'd4; rd_addr_b = 3'd5;
    tick();
    freeze = 1'b1; wr(3'd5, 64'h55);
    check("freeze_stage");
    tick();
    check("freeze_commit");
    tick();
    freeze = 1'b0; wr_valid = 1'b0;
    check("freeze_release");
    for (int i = 0; i < 7; i++) begin
      wr(3'(i), 64'(10 + i));
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(6 - i);
      tick();
      check($sformatf("sweep_wr%0d", i));
    end
    wr_valid = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(6 - i);
      check($sformatf("sweep_rd%0d", i));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
